// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery first-PE feeder: width defaults,
// feeder FSM states and the operand bank-select encoding.
package mont_pkg;

   localparam int RADIX_DEF     = 32;
   localparam int NUM_WORDS_DEF = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } feed_state_e;

   typedef enum logic {
      SEL_A = 1'b0,
      SEL_B = 1'b1
   } bank_sel_e;

endpackage

// File: rtl/pe_feed_opbank.sv
// Operand A/B register file: one write port, combinational A[i]/B[i] reads.
// With MONT_FEED_ZEROIZE_EN the whole bank clears on reset and on zeroize.
module pe_feed_opbank
   import mont_pkg::*;
#(
   parameter int  RADIX     = RADIX_DEF,
   parameter int  NUM_WORDS = NUM_WORDS_DEF,
   localparam int AW        = $clog2(NUM_WORDS)
) (
   input  logic             clk,
`ifdef MONT_FEED_ZEROIZE_EN
   input  logic             reset_n,
`endif
   input  logic             we,
   input  logic             sel,
   input  logic [AW-1:0]    waddr,
   input  logic [RADIX-1:0] wdata,
   input  logic             zeroize,
   input  logic [AW-1:0]    raddr,
   output logic [RADIX-1:0] a_rd,
   output logic [RADIX-1:0] b_rd
);

   logic [RADIX-1:0] bank [2][NUM_WORDS];

   assign a_rd = bank[SEL_A][raddr];
   assign b_rd = bank[SEL_B][raddr];

`ifdef MONT_FEED_ZEROIZE_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < 2; s++)
            for (int w = 0; w < NUM_WORDS; w++)
               bank[s][w] <= '0;
      end else if (zeroize) begin
         for (int s = 0; s < 2; s++)
            for (int w = 0; w < NUM_WORDS; w++)
               bank[s][w] <= '0;
      end else if (we) begin
         bank[sel][waddr] <= wdata;
      end
   end
`else
   // NOTE: the storage array has no reset; it only holds operand data, so
   // a reset would add a reset net to every bit for no functional gain.
   always_ff @(posedge clk) begin
      if (we && !zeroize)
         bank[sel][waddr] <= wdata;
   end
`endif

endmodule

// File: rtl/pe_first_feeder.sv
// Feeds operand words, fed-back partial sums and quotient words into the
// first systolic PE. Define MONT_FEED_ZEROIZE_EN to scrub operands after use.
module pe_first_feeder
   import mont_pkg::*;
#(
   parameter int RADIX     = RADIX_DEF,
   parameter int NUM_WORDS = NUM_WORDS_DEF,
   parameter int FLUSH_CYC = NUM_WORDS + 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         wr_en,
   input  logic                         wr_sel,
   input  logic [$clog2(NUM_WORDS)-1:0] wr_addr,
   input  logic [RADIX-1:0]             wr_data,
   input  logic                         start,
   input  logic                         abort,
   output logic                         busy,
   output logic                         done,
   input  logic [RADIX-1:0]             s_fb_in,
   input  logic [RADIX-1:0]             m_fb_in,
   output logic [RADIX-1:0]             a_in,
   output logic [RADIX-1:0]             b_in,
   output logic [RADIX-1:0]             s_in,
   output logic                         odd
);

   localparam int AW = $clog2(NUM_WORDS);
   localparam int KW = AW + 1;
   localparam int FW = $clog2(FLUSH_CYC + 1);
   localparam logic [KW-1:0] K_LAST = KW'(2 * NUM_WORDS - 1);
   localparam logic [FW-1:0] F_LAST = FW'(FLUSH_CYC - 1);

   feed_state_e      state, state_nxt;
   logic [KW-1:0]    k, k_nxt;
   logic [FW-1:0]    fcnt, fcnt_nxt;
   logic [RADIX-1:0] a_nxt, b_nxt, s_nxt;
   logic             odd_nxt;
   logic [RADIX-1:0] a_rd, b_rd;
   logic             bank_we, zeroize, live, wr_in_range;

   assign live        = (state == RUN) || (state == FLUSH);
   assign wr_in_range = {1'b0, wr_addr} < KW'(NUM_WORDS);
   assign bank_we     = wr_en && (state == IDLE) && wr_in_range;

   pe_feed_opbank #(
      .RADIX     (RADIX),
      .NUM_WORDS (NUM_WORDS)
   ) u_opbank (
      .clk     (clk),
`ifdef MONT_FEED_ZEROIZE_EN
      .reset_n (reset_n),
`endif
      .we      (bank_we),
      .sel     (wr_sel),
      .waddr   (wr_addr),
      .wdata   (wr_data),
      .zeroize (zeroize),
      .raddr   (k[KW-1:1]),
      .a_rd    (a_rd),
      .b_rd    (b_rd)
   );

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      fcnt_nxt  = fcnt;
      a_nxt     = '0;
      b_nxt     = '0;
      s_nxt     = '0;
      odd_nxt   = 1'b0;
      zeroize   = 1'b0;

      unique case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt = RUN;
               k_nxt     = '0;
            end
         end
         RUN: begin
            // Even k carries A[i] and the fed-back sum; odd k carries the quotient.
            odd_nxt = ~k[0];
            b_nxt   = b_rd;
            if (!k[0]) begin
               a_nxt = a_rd;
               s_nxt = s_fb_in;
            end else begin
               a_nxt = m_fb_in;
            end
            if (k == K_LAST) begin
               state_nxt = FLUSH;
               k_nxt     = '0;
               fcnt_nxt  = '0;
            end else begin
               k_nxt = k + 1'b1;
            end
         end
         FLUSH: begin
            if (fcnt == F_LAST) begin
               state_nxt = DONE;
               fcnt_nxt  = '0;
               zeroize   = 1'b1;
            end else begin
               fcnt_nxt = fcnt + 1'b1;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      if (abort && live) begin
         state_nxt = IDLE;
         k_nxt     = '0;
         fcnt_nxt  = '0;
         a_nxt     = '0;
         b_nxt     = '0;
         s_nxt     = '0;
         odd_nxt   = 1'b0;
         zeroize   = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         k     <= '0;
         fcnt  <= '0;
         a_in  <= '0;
         b_in  <= '0;
         s_in  <= '0;
         odd   <= 1'b0;
      end else begin
         state <= state_nxt;
         k     <= k_nxt;
         fcnt  <= fcnt_nxt;
         a_in  <= a_nxt;
         b_in  <= b_nxt;
         s_in  <= s_nxt;
         odd   <= odd_nxt;
      end
   end

   assign busy = live;
   assign done = (state == DONE);

endmodule

// File: doc/pe_first_feeder.md
PE_FIRST_FEEDER -- requirements
Module: pe_first_feeder

Interface
REQ-001 SHALL have parameter RADIX, default 32, meaning the word width in bits, equal to the systolic PE width.
REQ-002 SHALL have parameter NUM_WORDS, default 12, meaning the operand length in words (384-bit operands).
REQ-003 SHALL have parameter FLUSH_CYC, default NUM_WORDS+1, meaning the number of zero-drain cycles after the last operand word.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports wr_en (input, 1), wr_sel (input, 1; 0=A, 1=B), wr_addr (input, $clog2(NUM_WORDS)) and wr_data (input, RADIX): the operand load port.
REQ-007 SHALL have ports start (input, 1), abort (input, 1), busy (output, 1) and done (output, 1): the operation handshake.
REQ-008 SHALL have ports s_fb_in (input, RADIX), the partial-sum word fed back from the array, and m_fb_in (input, RADIX), the quotient word from the first PE.
REQ-009 SHALL have ports a_in, b_in and s_in (outputs, RADIX each) and odd (output, 1), all registered and driving the first PE.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, FLUSH and DONE.
REQ-011 IDLE: wr_en=1 SHALL write wr_data to bank[wr_sel][wr_addr] at the clock edge; a write while not IDLE SHALL be ignored; wr_addr>=NUM_WORDS SHALL be ignored.
REQ-012 IDLE->RUN on start=1; busy SHALL rise the cycle after start is sampled; start while busy=1 SHALL be ignored.
REQ-013 RUN SHALL last exactly 2*NUM_WORDS cycles, driven by phase counter k = 0 .. 2*NUM_WORDS-1 and word index i = k>>1.
REQ-014 odd SHALL be 1 when k is even and 0 when k is odd, so the first output cycle has odd=1.
REQ-015 odd=1 cycle: a_in=A[i], b_in=B[i], s_in=s_fb_in sampled in the same cycle.
REQ-016 odd=0 cycle: a_in=m_fb_in, b_in=B[i], s_in=0.
REQ-017 RUN->FLUSH after the k=2*NUM_WORDS-1 cycle; FLUSH SHALL drive a_in, b_in, s_in and odd to 0 for FLUSH_CYC cycles.
REQ-018 FLUSH->DONE; done SHALL be a single-cycle pulse in DONE, with busy=0 in that cycle; DONE->IDLE unconditionally.
REQ-019 abort=1 in RUN or FLUSH SHALL return to IDLE on the next edge, zero all data outputs and odd, and produce no done pulse; abort in IDLE or DONE SHALL have no effect.
REQ-020 start and abort asserted in the same cycle in IDLE: abort SHALL win and the FSM SHALL stay in IDLE.
REQ-021 The counters k, i and the flush counter SHALL wrap only through reset to 0 at state entry, never by modulo overflow.
REQ-022 Output latency: a bank word SHALL appear on a_in/b_in exactly one cycle after the FSM enters the corresponding k.

Reset
REQ-023 reset_n=0 SHALL asynchronously force the FSM to IDLE, busy=0, done=0, odd=0, a_in=b_in=s_in=0 and all counters to 0.
REQ-024 The operand bank SHALL NOT be reset unless MONT_FEED_ZEROIZE_EN is defined.
REQ-025 Reset asserted mid-RUN SHALL abandon the operation; after release the block SHALL be in IDLE awaiting start.

Configuration
REQ-026 With MONT_FEED_ZEROIZE_EN defined: the whole A/B bank SHALL be cleared to 0 on reset, on entry to DONE and on abort, so no operand residue persists for side-channel hygiene.
REQ-027 Without MONT_FEED_ZEROIZE_EN: the bank SHALL retain contents across operations, allowing re-start with the same operands.

Structure
REQ-028 Shared package mont_pkg SHALL hold the RADIX and NUM_WORDS defaults, the FSM state enum (feed_state_e) and the bank-select encoding.
REQ-029 The A/B register file SHALL be the sub-module pe_feed_opbank: one write port, two combinational read ports (A[i], B[i]), and a zeroize input.

Verification
REQ-030 The bench SHALL load A[j]=j+1 and B[j]=0x100+j, then start: expect a_in=1, b_in=0x100, odd=1 on the first RUN output cycle and odd alternating for 24 cycles, then 13 zero cycles, then one done pulse.
REQ-031 The bench SHALL drive m_fb_in=0xDEADBEEF during RUN: expect a_in=0xDEADBEEF and s_in=0 on every odd=0 cycle.
REQ-032 The bench SHALL assert abort at k=5: expect all outputs 0 and busy=0 on the next cycle, no done pulse, and a second start SHALL run a full operation.
REQ-033 The bench SHALL assert start and abort together in IDLE: expect busy to stay 0; a start pulse while busy SHALL not change the k sequence.
REQ-034 The bench SHALL assert reset_n=0 mid-FLUSH: expect outputs 0 immediately, without a clock edge.
REQ-035 With MONT_FEED_ZEROIZE_EN defined, the bench SHALL restart after done without reloading: expect a_in=0 and b_in=0 on all odd=1 cycles; without the macro, expect the original values.
